// File: rtl/counter_checker.sv
// On-chip driver/checker for an enable-gated counter: steps cnt_en through idle/run/hold/wrap
// phases, compares cnt_val with a reference each cycle. Optional macro: COUNTER_CHECKER_FIRST_ERR_EN.
module counter_checker #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned IDLE_CYCLES = 5,
  parameter int unsigned RUN_CYCLES  = 10,
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned WRAP_CYCLES = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_cnt_val,
  output logic             o_cnt_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  output logic [8:0]       o_first_err_idx,
`endif
  output logic [7:0]       o_err_count
);

  localparam int unsigned TOTAL_CHECKS = IDLE_CYCLES + RUN_CYCLES + HOLD_CYCLES + WRAP_CYCLES;
  localparam int unsigned IDX_W        = $clog2(TOTAL_CHECKS + 1);
  localparam int unsigned END_IDLE     = IDLE_CYCLES - 1;
  localparam int unsigned END_RUN      = IDLE_CYCLES + RUN_CYCLES - 1;
  localparam int unsigned END_HOLD     = IDLE_CYCLES + RUN_CYCLES + HOLD_CYCLES - 1;
  localparam int unsigned END_WRAP     = TOTAL_CHECKS - 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_PH_IDLE = 3'd2;
  localparam logic [2:0] S_PH_RUN  = 3'd3;
  localparam logic [2:0] S_PH_HOLD = 3'd4;
  localparam logic [2:0] S_PH_WRAP = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [8:0] NO_ERR_IDX = 9'h1FF;

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_chk_idx;
  logic [WIDTH-1:0] r_exp;
  logic             r_cnt_en;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [7:0]       r_err_count;

  logic [2:0]       w_state_nxt;
  logic [IDX_W-1:0] w_chk_idx_nxt;
  logic [WIDTH-1:0] w_exp_nxt;
  logic             w_cnt_en_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_pass_nxt;
  logic [7:0]       w_err_nxt;
  logic             w_in_phase;
  logic             w_mismatch;

`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  logic [8:0] r_first_err_idx;
  logic [8:0] w_first_nxt;
`endif

  assign w_in_phase = (r_state == S_PH_IDLE) || (r_state == S_PH_RUN) ||
                      (r_state == S_PH_HOLD) || (r_state == S_PH_WRAP);
  assign w_mismatch = w_in_phase && (i_cnt_val != r_exp);

  // Next-state, reference model and checker update
  always_comb begin
    w_state_nxt   = r_state;
    w_chk_idx_nxt = r_chk_idx;
    w_exp_nxt     = r_exp;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;
    w_err_nxt     = r_err_count;
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    w_first_nxt   = r_first_err_idx;
`endif

    if (w_in_phase) begin
      w_exp_nxt     = r_exp + WIDTH'(r_cnt_en);
      w_chk_idx_nxt = r_chk_idx + IDX_W'(1);
      if (w_mismatch) begin
        if (r_err_count != 8'hFF) w_err_nxt = r_err_count + 8'd1;
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
        if (r_first_err_idx == NO_ERR_IDX) w_first_nxt = 9'(r_chk_idx);
`endif
      end
    end

    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_SYNC;
      end
      S_SYNC: begin
        // Baseline is whatever the counter holds now; it need not be reset
        w_exp_nxt     = i_cnt_val;
        w_chk_idx_nxt = '0;
        w_err_nxt     = '0;
        w_done_nxt    = 1'b0;
        w_pass_nxt    = 1'b0;
        w_busy_nxt    = 1'b1;
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
        w_first_nxt   = NO_ERR_IDX;
`endif
        w_state_nxt   = S_PH_IDLE;
      end
      S_PH_IDLE: begin
        if (r_chk_idx == IDX_W'(END_IDLE)) w_state_nxt = S_PH_RUN;
      end
      S_PH_RUN: begin
        if (r_chk_idx == IDX_W'(END_RUN)) w_state_nxt = S_PH_HOLD;
      end
      S_PH_HOLD: begin
        if (r_chk_idx == IDX_W'(END_HOLD)) w_state_nxt = S_PH_WRAP;
      end
      S_PH_WRAP: begin
        if (r_chk_idx == IDX_W'(END_WRAP)) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_nxt == 8'd0);
        end
      end
      S_DONE: begin
        if (i_start) w_state_nxt = S_SYNC;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Enable takes its phase value in the first cycle of the phase
    w_cnt_en_nxt = (w_state_nxt == S_PH_RUN) || (w_state_nxt == S_PH_WRAP);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_chk_idx   <= '0;
      r_exp       <= '0;
      r_cnt_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_chk_idx   <= w_chk_idx_nxt;
      r_exp       <= w_exp_nxt;
      r_cnt_en    <= w_cnt_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_err_count <= w_err_nxt;
    end
  end

`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) r_first_err_idx <= NO_ERR_IDX;
    else       r_first_err_idx <= w_first_nxt;
  end

  assign o_first_err_idx = r_first_err_idx;
`endif

  assign o_cnt_en    = r_cnt_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: drives a behavioural 8-bit counter from the DUT's enable and
// scores each sequence against a phase-table model of what the checker must report.
module tb_counter_checker;

  localparam int N_CHK = 276;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cnt_val;
  logic       cnt_en;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  logic [8:0] first_err_idx;
`endif

  always #5 clk = ~clk;

  counter_checker dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_cnt_val      (cnt_val),
    .o_cnt_en       (cnt_en),
    .o_busy         (busy),
    .o_done         (done),
    .o_pass         (pass),
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    .o_first_err_idx(first_err_idx),
`endif
    .o_err_count    (err_count)
  );

  typedef struct {
    logic [7:0] preload;
    bit         drop;
    int         force_idx;
    int         exp_err;
    bit         exp_pass;
    int         exp_first;
    logic [7:0] exp_final;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] cnt_model;
  bit         drop_pending;
  logic [7:0] presented [N_CHK];
  int         m_err;
  int         m_first;
  bit         aborted;
  vec_t       tbl [4];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: behavioural counter increments when the enable seen this cycle was high
  task automatic tick();
    logic en;
    en = cnt_en;
    @(posedge clk);
    if (en) begin
      if (drop_pending) drop_pending = 1'b0;
      else cnt_model = cnt_model + 8'd1;
    end
    #1;
    cnt_val = cnt_model;
  endtask

  function automatic bit ideal_en(input int k);
    return (k >= 5 && k < 15) || (k >= 20 && k < 276);
  endfunction

  // Expected value at check k = baseline + enabled checks before k (mod 256)
  task automatic model_eval(input logic [7:0] base);
    logic [7:0] e;
    e = base;
    m_err = 0;
    m_first = 511;
    for (int k = 0; k < N_CHK; k++) begin
      if (presented[k] != e) begin
        if (m_err < 255) m_err++;
        if (m_first == 511) m_first = k;
      end
      if (ideal_en(k)) e = e + 8'd1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cnt_en"}, int'(cnt_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_count), 0);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    check({tag, "_first"}, int'(first_err_idx), 511);
`endif
  endtask

  task automatic run_seq(input bit drop, input int force_idx, input int restart_k,
                         input int rst_k, input bit rnd);
    logic [7:0] base;
    drop_pending = drop;
    aborted = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    base = cnt_model;
    tick();
    check("sync_busy", int'(busy), 1);
    check("sync_done_clr", int'(done), 0);
    check("sync_err_clr", int'(err_count), 0);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    check("sync_first_clr", int'(first_err_idx), 511);
`endif
    for (int k = 0; k < N_CHK; k++) begin
      if (k == force_idx || (rnd && $urandom_range(0, 63) == 0))
        cnt_val = cnt_model ^ 8'($urandom_range(1, 255));
      presented[k] = cnt_val;
      check($sformatf("cnt_en[%0d]", k), int'(cnt_en), int'(ideal_en(k)));
      if (k == N_CHK - 1) check("done_not_early", int'(done), 0);
      if (k == rst_k) begin
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check_reset_vals("midrst");
        tick();
        tick();
        check("rst_beats_start", int'(busy), 0);
        aborted = 1'b1;
        return;
      end
      if (k == restart_k || (rnd && $urandom_range(0, 31) == 0)) start = 1'b1;
      tick();
      start = 1'b0;
    end
    model_eval(base);
    check("end_done", int'(done), 1);
    check("end_busy", int'(busy), 0);
    check("end_cnt_en", int'(cnt_en), 0);
    check("end_err", int'(err_count), m_err);
    check("end_pass", int'(pass), int'(m_err == 0));
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    check("end_first", int'(first_err_idx), m_first);
`endif
  endtask

  initial begin
    tbl[0] = '{8'h00, 1'b0, -1, 0,   1'b1, 511, 8'h0A};
    tbl[1] = '{8'h37, 1'b0, -1, 0,   1'b1, 511, 8'h41};
    tbl[2] = '{8'h00, 1'b1, -1, 255, 1'b0, 6,   8'h09};
    tbl[3] = '{8'h00, 1'b0, 17, 1,   1'b0, 17,  8'h0A};

    rst = 1'b1;
    start = 1'b0;
    cnt_model = 8'h00;
    cnt_val = 8'h00;
    drop_pending = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals("reset");
    repeat (3) tick();
    check("idle_no_self_start", int'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      cnt_model = tbl[i].preload;
      cnt_val = cnt_model;
      tick();
      run_seq(tbl[i].drop, tbl[i].force_idx, -1, -1, 1'b0);
      check($sformatf("tbl%0d_err", i), int'(err_count), tbl[i].exp_err);
      check($sformatf("tbl%0d_pass", i), int'(pass), int'(tbl[i].exp_pass));
      check($sformatf("tbl%0d_final_cnt", i), int'(cnt_model), int'(tbl[i].exp_final));
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
      check($sformatf("tbl%0d_first", i), int'(first_err_idx), tbl[i].exp_first);
`endif
    end

    // Restart from DONE after the failing run: clears and passes again
    run_seq(1'b0, -1, -1, -1, 1'b0);
    check("done_restart_pass", int'(pass), 1);

    // start during PH_RUN is ignored; length checked inside run_seq
    run_seq(1'b0, -1, 7, -1, 1'b0);
    check("restart_ignored_pass", int'(pass), 1);

    // Reset during PH_WRAP after an error, then a clean run
    run_seq(1'b0, 30, -1, 100, 1'b0);
    check("rst_aborted", int'(aborted), 1);
    run_seq(1'b0, -1, -1, -1, 1'b0);
    check("post_rst_pass", int'(pass), 1);
    check("post_rst_err", int'(err_count), 0);

    for (int r = 0; r < 6; r++) begin
      cnt_model = 8'($urandom_range(0, 255));
      cnt_val = cnt_model;
      tick();
      run_seq(($urandom_range(0, 3) == 0), -1, -1, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
